// File: rtl/module_captura_operandos.sv
// Keypad operand capture: builds two sign-magnitude operands digit by digit
// and emits one-cycle commit strobes for the display selector and multiplier.
module module_captura_operandos #(
    parameter int unsigned MAX_MAG    = 255,
    parameter int unsigned MAX_DIGITS = 3,
    parameter logic [3:0]  KEY_NEG    = 4'hA,
    parameter logic [3:0]  KEY_ENTER  = 4'hB,
    parameter logic [3:0]  KEY_CLEAR  = 4'hC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] num_1,
    output logic       sig_1,
    output logic [7:0] num_2,
    output logic       sig_2,
    output logic       listo_1,
    output logic       listo_2,
    output logic       listo
);

    localparam int unsigned NW = 8;
    localparam int unsigned CANDW = 12;
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        ENTRADA_1 = 2'd0,
        ENTRADA_2 = 2'd1,
        CONFIRMA  = 2'd2,
        RESULTADO = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            key_valid_q;
    logic [NW-1:0]   num1_q, num1_d, num2_q, num2_d;
    logic            sig1_q, sig1_d, sig2_q, sig2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            listo_1_q, listo_1_d, listo_2_q, listo_2_d, listo_q, listo_d;

    logic             key_ev;
    logic             is_digit;
    logic             digit_ok;
    logic [NW-1:0]    act_num;
    logic [CANDW-1:0] cand;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ENTRADA_1;
            key_valid_q <= 1'b0;
            num1_q      <= '0;
            sig1_q      <= 1'b0;
            num2_q      <= '0;
            sig2_q      <= 1'b0;
            cnt_q       <= '0;
            listo_1_q   <= 1'b0;
            listo_2_q   <= 1'b0;
            listo_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid;
            num1_q      <= num1_d;
            sig1_q      <= sig1_d;
            num2_q      <= num2_d;
            sig2_q      <= sig2_d;
            cnt_q       <= cnt_d;
            listo_1_q   <= listo_1_d;
            listo_2_q   <= listo_2_d;
            listo_q     <= listo_d;
        end
    end

    // Next-state and operand editing
    always_comb begin
        state_d   = state_q;
        num1_d    = num1_q;
        sig1_d    = sig1_q;
        num2_d    = num2_q;
        sig2_d    = sig2_q;
        cnt_d     = cnt_q;
        listo_1_d = 1'b0;
        listo_2_d = 1'b0;
        listo_d   = 1'b0;

        key_ev   = key_valid & ~key_valid_q;
        is_digit = (key_code <= 4'd9);
        act_num  = (state_q == ENTRADA_2) ? num2_q : num1_q;
        // Wide candidate so out-of-range values are seen before truncation
        cand     = CANDW'(act_num) * CANDW'(10) + CANDW'(key_code);
        digit_ok = (cnt_q < CW'(MAX_DIGITS)) && (cand <= CANDW'(MAX_MAG));

        if (key_ev) begin
            if (key_code == KEY_CLEAR) begin
                num1_d    = '0;
                sig1_d    = 1'b0;
                num2_d    = '0;
                sig2_d    = 1'b0;
                cnt_d     = '0;
                state_d   = ENTRADA_1;
                listo_1_d = 1'b1;
            end else begin
                case (state_q)
                    ENTRADA_1: begin
                        if (is_digit) begin
                            if (digit_ok) begin
                                num1_d = cand[NW-1:0];
                                cnt_d  = cnt_q + CW'(1);
                            end
                        end else if (key_code == KEY_NEG) begin
                            sig1_d = ~sig1_q;
                        end else if (key_code == KEY_ENTER) begin
                            if (num1_q == '0) sig1_d = 1'b0;
                            num2_d    = '0;
                            sig2_d    = 1'b0;
                            cnt_d     = '0;
                            listo_1_d = 1'b1;
                            state_d   = ENTRADA_2;
                        end
                    end
                    ENTRADA_2: begin
                        if (is_digit) begin
                            if (digit_ok) begin
                                num2_d = cand[NW-1:0];
                                cnt_d  = cnt_q + CW'(1);
                            end
                        end else if (key_code == KEY_NEG) begin
                            sig2_d = ~sig2_q;
                        end else if (key_code == KEY_ENTER) begin
                            if (num2_q == '0) sig2_d = 1'b0;
                            listo_2_d = 1'b1;
                            state_d   = CONFIRMA;
                        end
                    end
                    CONFIRMA: begin
                        if (key_code == KEY_ENTER) begin
                            listo_d = 1'b1;
                            state_d = RESULTADO;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign num_1   = num1_q;
    assign sig_1   = sig1_q;
    assign num_2   = num2_q;
    assign sig_2   = sig2_q;
    assign listo_1 = listo_1_q;
    assign listo_2 = listo_2_q;
    assign listo   = listo_q;

endmodule

// File: tb/tb_module_captura_operandos.sv
// Directed bench for module_captura_operandos with hand-computed expectations.
module tb_module_captura_operandos;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] num_1, num_2;
    logic       sig_1, sig_2, listo_1, listo_2, listo;

    int n_cmp;
    int n_bad;
    int p1, p2, p0, q1, q2, q0;

    module_captura_operandos dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .num_1    (num_1),
        .sig_1    (sig_1),
        .num_2    (num_2),
        .sig_2    (sig_2),
        .listo_1  (listo_1),
        .listo_2  (listo_2),
        .listo    (listo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One key press; captures the strobes in the cycle after the event and the one after that
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        p1 = int'(listo_1); p2 = int'(listo_2); p0 = int'(listo);
        key_valid = 1'b0;
        @(negedge clk);
        q1 = int'(listo_1); q2 = int'(listo_2); q0 = int'(listo);
    endtask

    task automatic chk_ops(input string tag, input int n1, input int s1, input int n2, input int s2);
        chk({tag, ".num_1"}, int'(num_1), n1);
        chk({tag, ".sig_1"}, int'(sig_1), s1);
        chk({tag, ".num_2"}, int'(num_2), n2);
        chk({tag, ".sig_2"}, int'(sig_2), s2);
    endtask

    task automatic chk_strobe(input string tag, input int e1, input int e2, input int e0);
        chk({tag, ".listo_1"}, p1, e1);
        chk({tag, ".listo_2"}, p2, e2);
        chk({tag, ".listo"},   p0, e0);
        chk({tag, ".after"},   q1 + q2 + q0, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        repeat (3) @(negedge clk);
        chk_ops("reset", 0, 0, 0, 0);
        chk("reset.strobes", int'(listo_1) + int'(listo_2) + int'(listo), 0);
        rst = 1'b1;

        // 1,2,7,B -> operand 1 = 127, then operand 2 editable
        press(4'd1); press(4'd2); press(4'd7);
        chk("t1.num_1_pre", int'(num_1), 127);
        press(4'hB);
        chk_strobe("t1.enter", 1, 0, 0);
        chk_ops("t1.commit", 127, 0, 0, 0);
        press(4'd5);
        chk_ops("t1.op2", 127, 0, 5, 0);

        // Range and digit-count limits
        press(4'hC);
        chk_strobe("t2.clear", 1, 0, 0);
        chk_ops("t2.cleared", 0, 0, 0, 0);
        press(4'd2); press(4'd5); press(4'd6);
        chk("t2.over_max", int'(num_1), 25);
        press(4'd0);
        chk("t2.third_digit", int'(num_1), 250);
        press(4'd0);
        chk("t2.fourth_digit", int'(num_1), 250);

        // Signs, confirm and result strobes, frozen operands
        press(4'hC);
        press(4'hA); press(4'd4); press(4'd5); press(4'hB);
        chk_ops("t3.op1", 45, 1, 0, 0);
        press(4'hA); press(4'hA); press(4'hA); press(4'd9);
        chk_ops("t3.op2", 45, 1, 9, 1);
        press(4'hB);
        chk_strobe("t3.listo_2", 0, 1, 0);
        press(4'd3);
        chk_ops("t3.confirma_frozen", 45, 1, 9, 1);
        press(4'hB);
        chk_strobe("t3.listo", 0, 0, 1);
        press(4'd7); press(4'hA);
        chk_ops("t3.resultado_frozen", 45, 1, 9, 1);
        press(4'hB);
        chk_strobe("t3.enter_ignored", 0, 0, 0);

        // Negative zero is normalised at commit
        press(4'hC);
        press(4'hA); press(4'd0);
        chk("t4.sig_pre", int'(sig_1), 1);
        press(4'hB);
        chk_ops("t4.zero_sign", 0, 0, 0, 0);

        // Held key gives one event; code E ignored
        press(4'hC);
        @(negedge clk);
        key_code = 4'd3; key_valid = 1'b1;
        repeat (10) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        chk("t5.held", int'(num_1), 3);
        press(4'hE);
        chk("t5.code_e", int'(num_1), 3);
        chk_strobe("t5.code_e", 0, 0, 0);

        // Async reset mid operand 2
        press(4'hC);
        press(4'd1); press(4'hB); press(4'd4);
        chk_ops("t6.pre_rst", 1, 0, 4, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk_ops("t6.async", 0, 0, 0, 0);
        chk("t6.async_strobes", int'(listo_1) + int'(listo_2) + int'(listo), 0);
        @(negedge clk);
        chk("t6.held_strobes", int'(listo_1) + int'(listo_2) + int'(listo), 0);
        rst = 1'b1;
        press(4'd2); press(4'hB); press(4'd3); press(4'hB); press(4'hB);
        chk_strobe("t6.to_result", 0, 0, 1);
        chk_ops("t6.result_ops", 2, 0, 3, 0);
        press(4'hC);
        chk_strobe("t6.clear", 1, 0, 0);
        chk_ops("t6.cleared", 0, 0, 0, 0);
        press(4'd8);
        chk("t6.back_to_op1", int'(num_1), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/module_captura_operandos.md
Name: module_captura_operandos

Overview:
Keypad-side producer of the operand and control signals consumed by the display-priority selector and the multiplier. It takes decoded key codes from the keypad scanner and builds two sign-magnitude 8-bit operands digit by digit. It emits one-cycle commit strobes (listo_1, listo_2, listo) that steer the display priority and start the multiplication. Operand registers are live, so the display tracks typing in real time.

Parameters:
MAX_MAG, 255, largest accepted operand magnitude (must be ≤255)
MAX_DIGITS, 3, maximum decimal digits per operand
KEY_NEG, 4'hA, key code that toggles the sign of the operand being edited
KEY_ENTER, 4'hB, key code that commits the current step
KEY_CLEAR, 4'hC, key code that clears everything and returns to operand 1

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
key_valid  input  1  level from keypad scanner; a new key is the rising edge of this signal
key_code  input  4  decoded key (0–9 digits, A/B/C per parameters, D–F ignored); sampled on the key_valid rising edge
num_1  output  8  operand 1 magnitude
sig_1  output  1  operand 1 sign (1 = negative)
num_2  output  8  operand 2 magnitude
sig_2  output  1  operand 2 sign
listo_1  output  1  one-cycle pulse: operand 1 committed, or state cleared
listo_2  output  1  one-cycle pulse: operand 2 committed
listo  output  1  one-cycle pulse: multiply requested, result to be displayed

Behaviour:
- Reset (rst=0, async): all outputs 0; digit counter 0; key_valid edge-detect register 0; state ENTRADA_1. Reset dominates any simultaneous key.
- Key detect:
  - key_valid is registered once; key event = key_valid & ~key_valid_q.
  - key_code is sampled in the same cycle as the event.
  - Holding key_valid high produces exactly one event.
  - Strobes assert the cycle after the event edge (1-cycle latency) and last exactly one cycle.
- FSM states: ENTRADA_1, ENTRADA_2, CONFIRMA, RESULTADO.
- Digit d in ENTRADA_1 / ENTRADA_2:
  - Compute cand = num*10 + d at 12-bit width.
  - Accept only if digit_count < MAX_DIGITS and cand ≤ MAX_MAG; then num ← cand[7:0] and digit_count++.
  - Otherwise ignore; no state change.
  - Leading zeros count as digits.
- KEY_NEG in ENTRADA_1 / ENTRADA_2: toggles the sign of the active operand.
- KEY_ENTER:
  - ENTRADA_1 → ENTRADA_2. At commit, if num_1==0 then sig_1 ← 0. Pulse listo_1. Clear num_2, sig_2, digit_count.
  - ENTRADA_2 → CONFIRMA. Zero-sign rule applied to operand 2. Pulse listo_2.
  - CONFIRMA → RESULTADO. Pulse listo.
  - RESULTADO: ignored.
- KEY_CLEAR in any state:
  - num_1, sig_1, num_2, sig_2 and digit_count ← 0.
  - State → ENTRADA_1; pulse listo_1 so the display returns to operand 1.
- Ignored keys:
  - Digits and KEY_NEG in CONFIRMA and RESULTADO.
  - Codes D–F everywhere.
  - Operands are frozen from CONFIRMA onward until KEY_CLEAR.
- Only one strobe is ever high in a given cycle.
- An asynchronous reset mid-entry discards partial operands with no strobe.

Test Plan:
- Reset then keys 1,2,7,B → num_1=127, sig_1=0; listo_1 high exactly one cycle, one cycle after the B edge; state ENTRADA_2.
- Keys 2,5,6 in ENTRADA_1 → num_1 stays 25 after the 6 (256 > MAX_MAG). Further keys 0,0 → only the first 0 is accepted, giving 250; the second 0 is the 4th digit and is rejected.
- Sequence A,4,5,B,A,A,A,9,B,B → sig_1=1, num_1=45; sig_2=1, num_2=9. listo_2 and then listo pulse once each; further digits leave all operands unchanged.
- Keys A,0,B → num_1=0 and sig_1 forced to 0 at commit.
- key_valid held high 10 cycles with code 3 → exactly one digit entered (num_1=3). Code E pulse → no change.
- Mid-entry of operand 2, drive rst=0 asynchronously between clock edges → all outputs 0 immediately, no strobe. After release, KEY_CLEAR from RESULTADO → all operands 0 and a single listo_1 pulse.
